// File: rtl/sort_engine.sv
// Odd-even transposition sorter: captures N elements on start, runs N
// compare-swap phases, then publishes the sorted array and total swap count.
//
// state | meaning
// IDLE  | waiting for start_i; outputs hold the last result
// SORT  | one compare-swap phase per clock, N phases
// DONE  | publish working array and swap count, pulse done_o next cycle

module sort_engine #(
   parameter int N       = 8,
   parameter int DATA_W  = 32,
   parameter bit SIGNED  = 1'b1,
   parameter bit DESCEND = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  start_i,
   input  logic [N*DATA_W-1:0]   in_array_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [N*DATA_W-1:0]   out_array_o,
   output logic [$clog2(N*N):0]  swap_cnt_o
);

   localparam int CNT_W = $clog2(N*N) + 1;
   localparam int PH_W  = $clog2(N);

   typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

   state_t            state_q, state_d;
   logic [PH_W-1:0]   phase_q;
   logic [DATA_W-1:0] work_q [N];
   logic [DATA_W-1:0] work_d [N];
   logic [CNT_W-1:0]  acc_q;
   logic [CNT_W-1:0]  phase_swaps;
   logic              done_q;
   logic              last_phase;

   // Strict compare only: equal elements never move, keeping the sort stable.
   function automatic logic out_of_order(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
      logic gt;
      logic lt;
      if (SIGNED) begin
         gt = $signed(a) > $signed(b);
         lt = $signed(a) < $signed(b);
      end else begin
         gt = a > b;
         lt = a < b;
      end
      return DESCEND ? lt : gt;
   endfunction

   assign last_phase = (phase_q == PH_W'(N-1));

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = SORT;
         SORT:    if (last_phase) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == SORT);
      done_o = done_q;
   end

   // Even phases pair (0,1),(2,3)..; odd phases pair (1,2),(3,4)..
   always_comb begin
      work_d      = work_q;
      phase_swaps = '0;
      for (int i = 0; i < N-1; i++) begin
         if (((i % 2) == int'(phase_q[0])) && out_of_order(work_q[i], work_q[i+1])) begin
            work_d[i]   = work_q[i+1];
            work_d[i+1] = work_q[i];
            phase_swaps = phase_swaps + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         for (int k = 0; k < N; k++) work_q[k] <= '0;
         phase_q     <= '0;
         acc_q       <= '0;
         out_array_o <= '0;
         swap_cnt_o  <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  for (int k = 0; k < N; k++) work_q[k] <= in_array_i[k*DATA_W +: DATA_W];
                  phase_q <= '0;
                  acc_q   <= '0;
               end
            end
            SORT: begin
               work_q  <= work_d;
               phase_q <= phase_q + PH_W'(1);
               acc_q   <= acc_q + phase_swaps;
            end
            DONE: begin
               for (int k = 0; k < N; k++) out_array_o[k*DATA_W +: DATA_W] <= work_q[k];
               swap_cnt_o <= acc_q;
               done_q     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
